// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-serial length-prefixed program loader feeding the fetch stage.
// Optional checksum stage and error state enabled by `define PROG_LOADER_CKSUM_EN.
module prog_loader (
    input  logic        clk,
    input  logic        rstz,
    inout  wire         dvdd,
    inout  wire         dgnd,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_vld,
    output logic        byte_rdy,
    output logic [15:0] iout,
    output logic        pr,
    output logic        en,
    output logic [7:0]  word_cnt,
    output logic        done,
    output logic        err
);

`ifdef PROG_LOADER_CKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_PRON, S_HI, S_LO, S_WR, S_CK, S_EXIT, S_RUN, S_ERR
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_PRON, S_HI, S_LO, S_WR, S_EXIT, S_RUN
    } state_t;
`endif

    state_t      r_state;
    logic [7:0]  r_len;
    logic [7:0]  r_word_cnt;
    logic [15:0] r_iout;
    logic        r_byte_rdy;
    logic        r_pr;
    logic        r_en;
    logic        r_done;
    logic        w_xfer;
    logic [7:0]  w_cnt_next;
    logic        w_last;

    assign w_xfer     = byte_vld & r_byte_rdy;
    assign w_cnt_next = r_word_cnt + 8'd1;
    // Length 0 encodes 256 words: the 8-bit count wraps to 0 on the 256th write.
    assign w_last     = (w_cnt_next == r_len);

`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0] r_cksum;
    logic       r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state    <= S_IDLE;
            r_len      <= 8'd0;
            r_word_cnt <= 8'd0;
            r_iout     <= 16'd0;
            r_byte_rdy <= 1'b0;
            r_pr       <= 1'b0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
            r_cksum    <= 8'd0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_byte_rdy <= 1'b1;
                        r_state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        r_len      <= byte_in;
                        r_word_cnt <= 8'd0;
`ifdef PROG_LOADER_CKSUM_EN
                        r_cksum    <= 8'd0;
`endif
                        r_pr       <= 1'b1;
                        r_byte_rdy <= 1'b0;
                        r_state    <= S_PRON;
                    end
                end
                S_PRON: begin
                    r_byte_rdy <= 1'b1;
                    r_state    <= S_HI;
                end
                S_HI: begin
                    if (w_xfer) begin
                        r_iout[15:8] <= byte_in;
`ifdef PROG_LOADER_CKSUM_EN
                        r_cksum      <= r_cksum ^ byte_in;
`endif
                        r_state      <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_xfer) begin
                        r_iout[7:0] <= byte_in;
`ifdef PROG_LOADER_CKSUM_EN
                        r_cksum     <= r_cksum ^ byte_in;
`endif
                        r_en        <= 1'b1;
                        r_byte_rdy  <= 1'b0;
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    r_en       <= 1'b0;
                    r_word_cnt <= w_cnt_next;
                    if (w_last) begin
`ifdef PROG_LOADER_CKSUM_EN
                        r_byte_rdy <= 1'b1;
                        r_state    <= S_CK;
`else
                        r_pr       <= 1'b0;
                        r_state    <= S_EXIT;
`endif
                    end else begin
                        r_byte_rdy <= 1'b1;
                        r_state    <= S_HI;
                    end
                end
`ifdef PROG_LOADER_CKSUM_EN
                S_CK: begin
                    if (w_xfer) begin
                        r_byte_rdy <= 1'b0;
                        r_pr       <= 1'b0;
                        if (byte_in == r_cksum) begin
                            r_state <= S_EXIT;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    if (start) begin
                        r_err      <= 1'b0;
                        r_byte_rdy <= 1'b1;
                        r_state    <= S_LEN;
                    end
                end
`endif
                S_EXIT: begin
                    r_en    <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (start) begin
                        r_en       <= 1'b0;
                        r_done     <= 1'b0;
                        r_byte_rdy <= 1'b1;
                        r_state    <= S_LEN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_rdy = r_byte_rdy;
    assign iout     = r_iout;
    assign pr       = r_pr;
    assign en       = r_en;
    assign word_cnt = r_word_cnt;
    assign done     = r_done;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_vld = 1'b0;
    logic        byte_rdy;
    logic [15:0] iout;
    logic        pr, en, done, err;
    logic [7:0]  word_cnt;
    wire         dvdd_w = 1'b1;
    wire         dgnd_w = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] cap[$];
    int          pulses = 0;
    logic        wide = 1'b0;
    logic        prev_wr = 1'b0;
    logic [7:0]  tx [0:511];

    prog_loader dut (
        .clk(clk), .rstz(rstz), .dvdd(dvdd_w), .dgnd(dgnd_w), .start(start),
        .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(byte_rdy), .iout(iout),
        .pr(pr), .en(en), .word_cnt(word_cnt), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write pulses observed mid-cycle; a pulse lasting two cycles sets wide.
    always @(negedge clk) begin
        if (en && pr) begin
            if (prev_wr) wide = 1'b1;
            pulses++;
            cap.push_back(iout);
            prev_wr = 1'b1;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) step();
        byte_in  = b;
        byte_vld = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (byte_rdy) ok = 1'b1;
            step();
        end
        byte_vld = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_timeout got byte_rdy=0 want 1 for byte %h", b);
        end
    endtask

    task automatic session(input logic [7:0] len, input int nb, input int gap, input logic [7:0] cks);
        cap.delete();
        pulses = 0;
        wide   = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        send_byte(len, gap);
        for (int i = 0; i < nb; i++) send_byte(tx[i], gap);
`ifdef PROG_LOADER_CKSUM_EN
        send_byte(cks, gap);
`else
        if (cks === 8'hxx) $display("unused checksum");
`endif
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && !done; i++) step();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done got done=%b want 1", done);
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++; if ({pr, en, byte_rdy, done, err} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl got %b want 00000", {pr, en, byte_rdy, done, err}); end
        vectors++; if (iout !== 16'h0000) begin miscompares++; $display("FAIL reset_iout got %h want 0000", iout); end
        vectors++; if (word_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", word_cnt); end
        step();
        rstz = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        step();
        vectors++; if ({pr, byte_rdy, word_cnt} !== {2'b11, 8'd1}) begin miscompares++; $display("FAIL mid_hi got pr=%b rdy=%b cnt=%0d want 1 1 1", pr, byte_rdy, word_cnt); end
        rstz = 1'b0;
        #1;
        vectors++; if ({pr, en, byte_rdy} !== 3'b000) begin miscompares++; $display("FAIL async_reset_ctrl got %b want 000", {pr, en, byte_rdy}); end
        vectors++; if (word_cnt !== 8'd0) begin miscompares++; $display("FAIL async_reset_cnt got %0d want 0", word_cnt); end
        step();
        rstz = 1'b1;
        step();
        vectors++; if ({byte_rdy, pr, done} !== 3'b000) begin miscompares++; $display("FAIL idle_after_reset got %b want 000", {byte_rdy, pr, done}); end
    endtask

    task automatic test_two_word();
        tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'hF0; tx[3] = 8'h05;
        session(8'h02, 4, 0, 8'hD3);
`ifndef PROG_LOADER_CKSUM_EN
        vectors++; if ({en, pr, iout} !== {2'b11, 16'hF005}) begin miscompares++; $display("FAIL wr_cycle got en=%b pr=%b iout=%h want 1 1 f005", en, pr, iout); end
        step();
`endif
        vectors++; if ({pr, en, done} !== 3'b000) begin miscompares++; $display("FAIL exit_cycle got %b want 000", {pr, en, done}); end
        step();
        vectors++; if ({done, en, pr} !== 3'b110) begin miscompares++; $display("FAIL run_entry got %b want 110", {done, en, pr}); end
        vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL two_pulses got %0d want 2", pulses); end
        vectors++; if (cap[0] !== 16'h1234) begin miscompares++; $display("FAIL word0 got %h want 1234", cap[0]); end
        vectors++; if (cap[1] !== 16'hF005) begin miscompares++; $display("FAIL word1 got %h want f005", cap[1]); end
        vectors++; if (word_cnt !== 8'd2) begin miscompares++; $display("FAIL two_cnt got %0d want 2", word_cnt); end
        vectors++; if (wide !== 1'b0) begin miscompares++; $display("FAIL two_width got wide=%b want 0", wide); end
    endtask

    task automatic test_stalls();
        session(8'h02, 4, 3, 8'hD3);
        wait_done();
        vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL stall_pulses got %0d want 2", pulses); end
        vectors++; if (cap[0] !== 16'h1234) begin miscompares++; $display("FAIL stall_word0 got %h want 1234", cap[0]); end
        vectors++; if (cap[1] !== 16'hF005) begin miscompares++; $display("FAIL stall_word1 got %h want f005", cap[1]); end
        vectors++; if (word_cnt !== 8'd2) begin miscompares++; $display("FAIL stall_cnt got %0d want 2", word_cnt); end
        vectors++; if (wide !== 1'b0) begin miscompares++; $display("FAIL stall_width got wide=%b want 0", wide); end
    endtask

    task automatic test_n0();
        for (int i = 0; i < 512; i++) tx[i] = i[7:0];
        session(8'h00, 512, 0, 8'h00);
        wait_done();
        vectors++; if (pulses !== 256) begin miscompares++; $display("FAIL n0_pulses got %0d want 256", pulses); end
        vectors++; if (cap[0] !== 16'h0001) begin miscompares++; $display("FAIL n0_first got %h want 0001", cap[0]); end
        vectors++; if (cap[255] !== 16'hFEFF) begin miscompares++; $display("FAIL n0_last got %h want feff", cap[255]); end
        vectors++; if (word_cnt !== 8'd0) begin miscompares++; $display("FAIL n0_cnt got %0d want 0", word_cnt); end
    endtask

    task automatic test_restart();
        tx[0] = 8'hAB; tx[1] = 8'hCD;
        vectors++; if ({done, en} !== 2'b11) begin miscompares++; $display("FAIL pre_restart got %b want 11", {done, en}); end
        session(8'h01, 2, 0, 8'h66);
        wait_done();
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL restart_pulses got %0d want 1", pulses); end
        vectors++; if (cap[0] !== 16'hABCD) begin miscompares++; $display("FAIL restart_word got %h want abcd", cap[0]); end
        vectors++; if (word_cnt !== 8'd1) begin miscompares++; $display("FAIL restart_cnt got %0d want 1", word_cnt); end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if ({en, done, byte_rdy} !== 3'b001) begin miscompares++; $display("FAIL run_start got %b want 001", {en, done, byte_rdy}); end
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
`ifdef PROG_LOADER_CKSUM_EN
        send_byte(8'hFF, 0);
`endif
        wait_done();
    endtask

`ifdef PROG_LOADER_CKSUM_EN
    task automatic test_cksum();
        tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'hF0; tx[3] = 8'h05;
        session(8'h02, 4, 0, 8'hD3);
        step();
        vectors++; if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL cksum_good got %b want 10", {done, err}); end
        session(8'h02, 4, 0, 8'h00);
        step();
        vectors++; if ({err, pr, en, done} !== 4'b1000) begin miscompares++; $display("FAIL cksum_bad got %b want 1000", {err, pr, en, done}); end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++; if ({err, byte_rdy} !== 2'b01) begin miscompares++; $display("FAIL err_clear got %b want 01", {err, byte_rdy}); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_word();
        test_stalls();
        test_n0();
        test_restart();
`ifdef PROG_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
